// File: rtl/apb_gpio_bank_pkg.sv
// apb_gpio_bank_pkg: register offsets and the per-port window width shared by the GPIO bank.
package apb_gpio_bank_pkg;
    localparam int GPIO_WIN_W = 6;
    localparam logic [5:0] GPIO_OFS_DATA    = 6'h00;
    localparam logic [5:0] GPIO_OFS_DOUT    = 6'h04;
    localparam logic [5:0] GPIO_OFS_DOUTSET = 6'h08;
    localparam logic [5:0] GPIO_OFS_DOUTCLR = 6'h0C;
    localparam logic [5:0] GPIO_OFS_DOUTTGL = 6'h10;
    localparam logic [5:0] GPIO_OFS_OUTEN   = 6'h14;
    localparam logic [5:0] GPIO_OFS_INTEN   = 6'h18;
    localparam logic [5:0] GPIO_OFS_INTTYPE = 6'h1C;
    localparam logic [5:0] GPIO_OFS_INTPOL  = 6'h20;
    localparam logic [5:0] GPIO_OFS_INTBOTH = 6'h24;
    localparam logic [5:0] GPIO_OFS_INTSTAT = 6'h28;
    localparam logic [5:0] GPIO_OFS_DBEN    = 6'h2C;
    localparam logic [5:0] GPIO_OFS_DBCNT   = 6'h30;

    function automatic logic gpio_ofs_ok(input logic [5:0] ofs);
        return ofs <= GPIO_OFS_DBCNT;
    endfunction
endpackage

// File: rtl/gpio_bank_port.sv
// gpio_bank_port: one GPIO port - registers, 2-FF input sync, debounce and interrupt detect.
module gpio_bank_port
    import apb_gpio_bank_pkg::*;
#(
    parameter int PW    = 8,
    parameter int DBW   = 16,
    parameter int DBSMP = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [5:0]    i_ofs,
    input  logic [31:0]   i_wdata,
    input  logic [PW-1:0] i_pin,
    output logic [31:0]   o_rdata,
    output logic [PW-1:0] o_dout,
    output logic [PW-1:0] o_outen,
    output logic [PW-1:0] o_int
);
    logic [PW-1:0]  r_dout, r_outen, r_inten, r_inttype, r_intpol, r_intboth, r_intstat, r_dben;
    logic [PW-1:0]  r_s1, r_s2, r_deb, r_prev;
    logic [DBW-1:0] r_dbcnt, r_pre;
    logic [3:0]     r_cnt [PW];
    logic [PW-1:0]  w_wd, w_data, w_hit, w_set, w_clr;
    logic           w_tick, w_dbw, w_unused;

    assign w_wd     = i_wdata[PW-1:0];
    assign w_unused = ^i_wdata;
    assign w_data   = (r_dben & r_deb) | (~r_dben & r_s2);
    assign w_tick   = r_pre == r_dbcnt;
    assign w_dbw    = i_we && i_ofs == GPIO_OFS_DBCNT;
    // w_hit: DATA matches polarity, which is both the level condition and the edge direction
    assign w_hit    = ~(w_data ^ r_intpol);
    assign w_set    = (r_inttype & (w_data ^ r_prev) & (r_intboth | w_hit)) | (~r_inttype & w_hit);
    assign w_clr    = (i_we && i_ofs == GPIO_OFS_INTSTAT) ? w_wd : '0;
    assign o_dout   = r_dout;
    assign o_outen  = r_outen;
    assign o_int    = r_intstat & r_inten;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {r_dout, r_outen, r_inten, r_inttype, r_intpol, r_intboth, r_intstat, r_dben} <= '0;
            {r_s1, r_s2, r_prev} <= '0;
            r_dbcnt <= '0;
            r_pre   <= '0;
        end else begin
            r_s1      <= i_pin;
            r_s2      <= r_s1;
            r_prev    <= w_data;
            r_pre     <= (w_tick || w_dbw) ? '0 : r_pre + DBW'(1);
            r_intstat <= (r_intstat & ~w_clr) | w_set;
            if (i_we) begin
                case (i_ofs)
                    GPIO_OFS_DOUT:    r_dout    <= w_wd;
                    GPIO_OFS_DOUTSET: r_dout    <= r_dout | w_wd;
                    GPIO_OFS_DOUTCLR: r_dout    <= r_dout & ~w_wd;
                    GPIO_OFS_DOUTTGL: r_dout    <= r_dout ^ w_wd;
                    GPIO_OFS_OUTEN:   r_outen   <= w_wd;
                    GPIO_OFS_INTEN:   r_inten   <= w_wd;
                    GPIO_OFS_INTTYPE: r_inttype <= w_wd;
                    GPIO_OFS_INTPOL:  r_intpol  <= w_wd;
                    GPIO_OFS_INTBOTH: r_intboth <= w_wd;
                    GPIO_OFS_DBEN:    r_dben    <= w_wd;
                    GPIO_OFS_DBCNT:   r_dbcnt   <= i_wdata[DBW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Undebounced bits shadow the sync value so enabling debounce starts from the live level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_deb <= '0;
            for (int b = 0; b < PW; b++) r_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < PW; b++) begin
                if (!r_dben[b] || r_s2[b] == r_deb[b]) begin
                    r_deb[b] <= r_s2[b];
                    r_cnt[b] <= '0;
                end else if (w_tick) begin
                    if (r_cnt[b] == 4'(DBSMP - 1)) begin
                        r_deb[b] <= r_s2[b];
                        r_cnt[b] <= '0;
                    end else begin
                        r_cnt[b] <= r_cnt[b] + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_ofs)
            GPIO_OFS_DATA:    o_rdata = 32'(w_data);
            GPIO_OFS_DOUT:    o_rdata = 32'(r_dout);
            GPIO_OFS_OUTEN:   o_rdata = 32'(r_outen);
            GPIO_OFS_INTEN:   o_rdata = 32'(r_inten);
            GPIO_OFS_INTTYPE: o_rdata = 32'(r_inttype);
            GPIO_OFS_INTPOL:  o_rdata = 32'(r_intpol);
            GPIO_OFS_INTBOTH: o_rdata = 32'(r_intboth);
            GPIO_OFS_INTSTAT: o_rdata = 32'(r_intstat);
            GPIO_OFS_DBEN:    o_rdata = 32'(r_dben);
            GPIO_OFS_DBCNT:   o_rdata = 32'(r_dbcnt);
            default: ;
        endcase
    end
endmodule

// File: rtl/apb_gpio_bank.sv
// apb_gpio_bank: APB3 slot holding NPORTS GPIO ports; top does address decode, read mux and PSLVERR.
module apb_gpio_bank
    import apb_gpio_bank_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int PW     = 8,
    parameter int DBW    = 16,
    parameter int DBSMP  = 3
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 PSEL,
    input  logic [11:0]          PADDR,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    input  logic [NPORTS*PW-1:0] PORTIN,
    output logic [NPORTS*PW-1:0] PORTOUT,
    output logic [NPORTS*PW-1:0] PORTEN,
    output logic [NPORTS*PW-1:0] GPIOINT,
    output logic [NPORTS-1:0]    COMBINT
);
    logic [5:0]  w_port, w_ofs;
    logic        w_acc, w_ok, w_wr;
    logic [31:0] w_rd [NPORTS];
    logic [31:0] w_sel;

    assign w_port  = PADDR[11:GPIO_WIN_W];
    assign w_ofs   = PADDR[5:0] & 6'h3C;
    assign w_acc   = PSEL && PENABLE;
    assign w_ok    = gpio_ofs_ok(w_ofs) && ({26'd0, w_port} < 32'(NPORTS));
    assign w_wr    = w_acc && PWRITE && w_ok;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_acc && !w_ok;
    assign PRDATA  = (w_acc && !PWRITE && w_ok) ? w_sel : '0;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NPORTS; i++) w_sel = (w_port == 6'(i)) ? w_rd[i] : w_sel;
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        gpio_bank_port #(.PW(PW), .DBW(DBW), .DBSMP(DBSMP)) u_port (
            .i_clk   (PCLK),
            .i_rst   (PRESET),
            .i_we    (w_wr && w_port == 6'(p)),
            .i_ofs   (w_ofs),
            .i_wdata (PWDATA),
            .i_pin   (PORTIN[p*PW +: PW]),
            .o_rdata (w_rd[p]),
            .o_dout  (PORTOUT[p*PW +: PW]),
            .o_outen (PORTEN[p*PW +: PW]),
            .o_int   (GPIOINT[p*PW +: PW])
        );
        assign COMBINT[p] = |GPIOINT[p*PW +: PW];
    end
endmodule

// File: tb/tb_apb_gpio_bank.sv
// tb_apb_gpio_bank: directed APB vectors against hand-computed values for the 2x8 GPIO bank.
module tb_apb_gpio_bank;
    logic        PCLK = 0, PRESET = 1, PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0, PRDATA;
    logic        PREADY, PSLVERR;
    logic [15:0] PORTIN = '0, PORTOUT, PORTEN, GPIOINT;
    logic [1:0]  COMBINT;
    int          n_chk = 0, n_err = 0, cyc = 0;
    logic [31:0] rd;
    logic        er;

    apb_gpio_bank #(.NPORTS(2), .PW(8), .DBW(16), .DBSMP(3)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PORTIN(PORTIN), .PORTOUT(PORTOUT), .PORTEN(PORTEN), .GPIOINT(GPIOINT), .COMBINT(COMBINT)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1;
        #1;
        d = PRDATA;
        e = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        int t0, lat;
        logic seen;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 0;
        repeat (2) @(posedge PCLK);
        // Level-low is the reset interrupt type, so idle-low inputs latch INTSTAT at once
        for (int o = 0; o <= 'h30; o += 4) begin
            apb_read(12'(o), rd, er);
            chk($sformatf("rst_rd_%0h", o), rd, (o == 'h28) ? 32'hFF : 32'h0);
            chk($sformatf("rst_err_%0h", o), {31'd0, er}, 32'h0);
        end
        chk("pready", {31'd0, PREADY}, 32'h1);
        chk("rst_portout", {16'd0, PORTOUT}, 32'h0);

        apb_write(12'h004, 32'h0F);
        apb_write(12'h008, 32'h30);
        apb_write(12'h00C, 32'h01);
        apb_write(12'h010, 32'h81);
        apb_read(12'h004, rd, er);
        chk("dout_atomic", rd, 32'hBF);
        apb_write(12'h044, 32'hA5);
        chk("portout", {16'd0, PORTOUT}, 32'hA5BF);

        apb_write(12'h014, 32'hFF);
        chk("porten", {16'd0, PORTEN}, 32'h00FF);
        apb_read(12'h034, rd, er);
        chk("bad_ofs_err", {31'd0, er}, 32'h1);
        chk("bad_ofs_rd", rd, 32'h0);
        apb_read(12'h080, rd, er);
        chk("bad_port_err", {31'd0, er}, 32'h1);
        chk("bad_port_rd", rd, 32'h0);
        apb_read(12'h014, rd, er);
        chk("outen", rd, 32'hFF);

        apb_write(12'h01C, 32'hFF);
        apb_write(12'h020, 32'h04);
        apb_write(12'h028, 32'hFF);
        apb_write(12'h018, 32'h04);
        apb_read(12'h028, rd, er);
        chk("intstat_clr", rd, 32'h0);
        PORTIN[2] = 1;
        repeat (4) @(posedge PCLK);
        #1;
        chk("gpioint_rise", {16'd0, GPIOINT}, 32'h0004);
        chk("combint_rise", {30'd0, COMBINT}, 32'h1);
        apb_read(12'h028, rd, er);
        chk("intstat_rise", rd, 32'h04);
        apb_read(12'h000, rd, er);
        chk("data_bit2", rd, 32'h04);
        apb_write(12'h028, 32'h04);
        chk("gpioint_w1c", {16'd0, GPIOINT}, 32'h0);
        chk("combint_w1c", {30'd0, COMBINT}, 32'h0);
        apb_read(12'h028, rd, er);
        chk("intstat_w1c", rd, 32'h0);
        PORTIN[2] = 0;
        repeat (5) @(posedge PCLK);
        apb_read(12'h028, rd, er);
        chk("intstat_fall", rd, 32'h0);

        apb_write(12'h02C, 32'h01);
        apb_write(12'h030, 32'h9);
        apb_read(12'h030, rd, er);
        chk("dbcnt", rd, 32'h9);
        @(posedge PCLK); #1;
        PORTIN[0] = 1;
        repeat (20) @(posedge PCLK);
        #1 PORTIN[0] = 0;
        repeat (15) @(posedge PCLK);
        apb_read(12'h000, rd, er);
        chk("db_glitch", rd, 32'h0);
        @(posedge PCLK); #1;
        PORTIN[0] = 1;
        t0 = cyc;
        seen = 0;
        lat = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            apb_read(12'h000, rd, er);
            if (rd[0]) begin
                seen = 1;
                lat = cyc - t0;
            end
        end
        chk("db_accept", {31'd0, seen}, 32'h1);
        chk("db_latency", {31'd0, (lat >= 20 && lat <= 42)}, 32'h1);

        apb_write(12'h020, 32'h06);
        apb_write(12'h01C, 32'hFD);
        PORTIN[1] = 1;
        repeat (4) @(posedge PCLK);
        apb_write(12'h028, 32'hFF);
        apb_read(12'h028, rd, er);
        chk("level_resets", rd, 32'h02);
        chk("inten_gates", {16'd0, GPIOINT}, 32'h0);

        @(posedge PCLK); #1;
        PSEL = 1; PWRITE = 1; PADDR = 12'h004; PWDATA = 32'h55;
        @(posedge PCLK); #1;
        PENABLE = 1;
        #2 PRESET = 1;
        #1;
        chk("rst_out", {16'd0, PORTOUT}, 32'h0);
        chk("rst_en", {16'd0, PORTEN}, 32'h0);
        chk("rst_int", {14'd0, COMBINT, GPIOINT}, 32'h0);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        @(posedge PCLK); #1;
        PRESET = 0;
        apb_read(12'h004, rd, er);
        chk("rst_abort", rd, 32'h0);
        chk("rst_pready", {31'd0, PREADY}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
